addsub_iter: RTL and testbench

Parametrised, multi-cycle integer add/subtract/compare unit for the RV32I datapath. It computes ADD, SUB, SLT and SLTU over `WIDTH` bits, processing `CHUNK` bits per cycle with a registered carry chain, and reports carry, overflow and zero flags. A valid/ready handshake on both sides lets the ALU issue work and stall on the result, trading latency for LUT/carry-chain area on the iCE40.

---
 rtl/addsub_iter.sv | 127 ++++++++++++
 tb/tb_addsub_iter.sv | 181 ++++++++++++++++++
 2 files changed

// File: rtl/addsub_iter.sv
// Multi-cycle ADD/SUB/SLT/SLTU unit: CHUNK bits per RUN cycle through a registered carry,
// with valid/ready handshakes on the operand and result sides.
module addsub_iter #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic             out_carry,
  output logic             out_overflow,
  output logic             out_zero
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int IDX_W  = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;

  generate
    if (WIDTH % CHUNK != 0) begin : g_bad_chunk
      $error("addsub_iter: WIDTH must be a multiple of CHUNK");
    end
  endgenerate

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_e;
  typedef enum logic [1:0] {OP_ADD = 2'b00, OP_SUB = 2'b01, OP_SLT = 2'b10, OP_SLTU = 2'b11} op_e;

  state_e             state_q;
  op_e                op_q;
  logic [WIDTH-1:0]   a_q, b_q, result_q;
  logic [IDX_W-1:0]   idx_q;
  logic               carry_q;
  logic               out_valid_q, out_carry_q, out_overflow_q, out_zero_q;

  logic [CHUNK-1:0]   a_s, b_s, bp_s, sum_s;
  logic               cout, cin_msb, ovf, last_chunk;
  logic [WIDTH-1:0]   sum_full, final_res;

  // Operands shift right each RUN cycle so the active chunk is always the low slice,
  // while sum slices enter the result from the top; after NCHUNK cycles it is aligned.
  // NOTE: every always_comb output is assigned a default first so no latch is inferred.
  always_comb begin
    a_s      = a_q[CHUNK-1:0];
    b_s      = b_q[CHUNK-1:0];
    bp_s     = (op_q == OP_ADD) ? b_s : ~b_s;
    {cout, sum_s} = {1'b0, a_s} + {1'b0, bp_s} + (CHUNK+1)'(carry_q);
    cin_msb  = a_s[CHUNK-1] ^ bp_s[CHUNK-1] ^ sum_s[CHUNK-1];
    ovf      = cin_msb ^ cout;
    sum_full = result_q >> CHUNK;
    sum_full[WIDTH-1 -: CHUNK] = sum_s;
    case (op_q)
      OP_SLT:  final_res = {{(WIDTH-1){1'b0}}, sum_full[WIDTH-1] ^ ovf};
      OP_SLTU: final_res = {{(WIDTH-1){1'b0}}, ~cout};
      default: final_res = sum_full;
    endcase
  end

  assign last_chunk = (idx_q == IDX_W'(NCHUNK - 1));
  assign in_ready   = (state_q == S_IDLE) && rst_n;

  // NOTE: sequential state uses non-blocking assignments only; the data registers are
  // reset as well so no output can show X after reset and no partial result survives it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= S_IDLE;
      op_q           <= OP_ADD;
      a_q            <= '0;
      b_q            <= '0;
      result_q       <= '0;
      idx_q          <= '0;
      carry_q        <= 1'b0;
      out_valid_q    <= 1'b0;
      out_carry_q    <= 1'b0;
      out_overflow_q <= 1'b0;
      out_zero_q     <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (in_valid) begin
            a_q     <= in_a;
            b_q     <= in_b;
            op_q    <= op_e'(in_op);
            carry_q <= (in_op != 2'b00);
            idx_q   <= '0;
            state_q <= S_RUN;
          end
        end
        S_RUN: begin
          a_q     <= a_q >> CHUNK;
          b_q     <= b_q >> CHUNK;
          carry_q <= cout;
          idx_q   <= idx_q + IDX_W'(1);
          if (last_chunk) begin
            result_q       <= final_res;
            out_carry_q    <= cout;
            out_overflow_q <= ovf;
            out_zero_q     <= (final_res == '0);
            out_valid_q    <= 1'b1;
            state_q        <= S_DONE;
          end else begin
            result_q <= sum_full;
          end
        end
        S_DONE: begin
          if (out_ready) begin
            out_valid_q <= 1'b0;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign out_valid    = out_valid_q;
  assign out_result   = result_q;
  assign out_carry    = out_carry_q;
  assign out_overflow = out_overflow_q;
  assign out_zero     = out_zero_q;

endmodule

// File: tb/tb_addsub_iter.sv
// Directed bench for addsub_iter: a 32/16 instance for function, latency, backpressure
// and reset, plus a 32/8 instance for the four-chunk latency case.
module tb_addsub_iter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0, in_valid8 = 1'b0;
  logic [1:0]  in_op = 2'b00;
  logic [31:0] in_a = '0, in_b = '0;
  logic        out_ready = 1'b0;

  logic        in_ready, out_valid, out_carry, out_overflow, out_zero;
  logic [31:0] out_result;
  logic        in_ready8, out_valid8, out_carry8, out_overflow8, out_zero8;
  logic [31:0] out_result8;

  logic        sel8 = 1'b0;
  logic        ir, ov, oc, oo, oz;
  logic [31:0] orr;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  addsub_iter #(.WIDTH(32), .CHUNK(16)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_carry(out_carry), .out_overflow(out_overflow),
    .out_zero(out_zero)
  );

  addsub_iter #(.WIDTH(32), .CHUNK(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8), .in_op(in_op),
    .in_a(in_a), .in_b(in_b), .out_valid(out_valid8), .out_ready(out_ready),
    .out_result(out_result8), .out_carry(out_carry8), .out_overflow(out_overflow8),
    .out_zero(out_zero8)
  );

  assign ir  = sel8 ? in_ready8     : in_ready;
  assign ov  = sel8 ? out_valid8    : out_valid;
  assign orr = sel8 ? out_result8   : out_result;
  assign oc  = sel8 ? out_carry8    : out_carry;
  assign oo  = sel8 ? out_overflow8 : out_overflow;
  assign oz  = sel8 ? out_zero8     : out_zero;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Issue at a negedge, accept on the next posedge, return at the first negedge with out_valid.
  task automatic issue(input string tag, input logic [1:0] op, input logic [31:0] a,
                       input logic [31:0] b, input int exp_lat);
    int lat;
    @(negedge clk);
    check({tag, ".in_ready"}, 32'(ir), 32'd1);
    in_op = op; in_a = a; in_b = b;
    if (sel8) in_valid8 = 1'b1; else in_valid = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_valid8 = 1'b0;
    lat = 0;
    @(negedge clk);
    while (!ov && lat < 20) begin
      @(negedge clk);
      lat++;
    end
    check({tag, ".latency"}, 32'(lat), 32'(exp_lat));
  endtask

  task automatic check_res(input string tag, input logic [31:0] res, input logic c,
                           input logic v, input logic z);
    check({tag, ".result"},   orr,     res);
    check({tag, ".carry"},    32'(oc), 32'(c));
    check({tag, ".overflow"}, 32'(oo), 32'(v));
    check({tag, ".zero"},     32'(oz), 32'(z));
  endtask

  // Called at a negedge with out_valid high: complete the handshake and confirm IDLE.
  task automatic drain(input string tag);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check({tag, ".ready_after"}, 32'(ir), 32'd1);
    check({tag, ".valid_after"}, 32'(ov), 32'd0);
  endtask

  task automatic vec(input string tag, input logic [1:0] op, input logic [31:0] a,
                     input logic [31:0] b, input int exp_lat, input logic [31:0] res,
                     input logic c, input logic v, input logic z);
    issue(tag, op, a, b, exp_lat);
    check_res(tag, res, c, v, z);
    drain(tag);
  endtask

  initial begin
    #2;
    check("rst.out_valid",  32'(out_valid), 32'd0);
    check("rst.in_ready",   32'(in_ready),  32'd0);
    check("rst.out_result", out_result,     32'd0);
    check("rst.flags", {29'd0, out_carry, out_overflow, out_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    #1 check("rst.ready_release", 32'(in_ready), 32'd1);

    vec("add_wrap",  2'b00, 32'hFFFF_FFFF, 32'h0000_0001, 2, 32'h0000_0000, 1, 0, 1);
    vec("sub_ovf",   2'b01, 32'h8000_0000, 32'h0000_0001, 2, 32'h7FFF_FFFF, 1, 1, 0);
    vec("sub_eq",    2'b01, 32'd5,         32'd5,         2, 32'h0000_0000, 1, 0, 1);
    vec("sub_borrow",2'b01, 32'd1,         32'd2,         2, 32'hFFFF_FFFF, 0, 0, 0);
    vec("add_ovf",   2'b00, 32'h7FFF_FFFF, 32'h0000_0001, 2, 32'h8000_0000, 0, 1, 0);
    vec("slt_neg",   2'b10, 32'hFFFF_FFFF, 32'h0000_0001, 2, 32'h0000_0001, 1, 0, 0);
    vec("sltu_big",  2'b11, 32'hFFFF_FFFF, 32'h0000_0001, 2, 32'h0000_0000, 1, 0, 1);
    vec("slt_pos",   2'b10, 32'h0000_0001, 32'hFFFF_FFFF, 2, 32'h0000_0000, 0, 0, 1);
    vec("slt_vflip", 2'b10, 32'h8000_0000, 32'h0000_0001, 2, 32'h0000_0001, 1, 1, 0);
    vec("sltu_lt",   2'b11, 32'h0000_0001, 32'hFFFF_FFFF, 2, 32'h0000_0001, 0, 0, 0);

    // Backpressure: result held while new operands are offered and ignored.
    issue("bp", 2'b00, 32'd3, 32'd4, 2);
    in_op = 2'b00; in_a = 32'd10; in_b = 32'd20; in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("bp.hold_valid", 32'(out_valid), 32'd1);
      check("bp.hold_ready", 32'(in_ready),  32'd0);
      check_res("bp.hold", 32'd7, 0, 0, 0);
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    @(negedge clk);
    check("bp.ready_next", 32'(in_ready), 32'd1);
    @(posedge clk);
    #1 in_valid = 1'b0;
    begin
      int lat = 0;
      @(negedge clk);
      while (!out_valid && lat < 20) begin
        @(negedge clk);
        lat++;
      end
      check("bp2.latency", 32'(lat), 32'd2);
    end
    check_res("bp2", 32'd30, 0, 0, 0);
    drain("bp2");

    // Reset one cycle into RUN.
    @(negedge clk);
    in_op = 2'b00; in_a = 32'd9; in_b = 32'd9; in_valid = 1'b1;
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("mrst.out_valid",  32'(out_valid), 32'd0);
    check("mrst.in_ready",   32'(in_ready),  32'd0);
    check("mrst.out_result", out_result,     32'd0);
    check("mrst.flags", {29'd0, out_carry, out_overflow, out_zero}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    vec("mrst_add", 2'b00, 32'd3, 32'd4, 2, 32'd7, 0, 0, 0);

    sel8 = 1'b1;
    vec("c8_add", 2'b00, 32'h00FF_00FF, 32'h0001_0001, 4, 32'h0100_0100, 0, 0, 0);
    vec("c8_sub", 2'b01, 32'h0000_0000, 32'h0000_0001, 4, 32'hFFFF_FFFF, 0, 0, 0);
    sel8 = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
